// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide,
// one operation in flight, start/done handshake with flush and RISC-V divide special cases.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            enable,
  input  logic [2:0]      command,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] CMD_MUL    = 3'd0;
  localparam logic [2:0] CMD_MULH   = 3'd1;
  localparam logic [2:0] CMD_MULHSU = 3'd2;
  localparam logic [2:0] CMD_DIV    = 3'd4;
  localparam logic [2:0] CMD_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {Idle, Mul, Div, Done} state_t;

  state_t          state, next_state;
  logic [4:0]      cnt;
  logic [2:0]      cmd;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] mag, acc_hi, acc_lo;

  // Operand decode, only meaningful while Idle.
  logic            sgn1, sgn2, a_neg, b_neg, is_div, div_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign is_div   = command[2];
  assign sgn1     = (command == CMD_MUL) || (command == CMD_MULH) || (command == CMD_MULHSU) ||
                    (command == CMD_DIV) || (command == CMD_REM);
  assign sgn2     = (command == CMD_MUL) || (command == CMD_MULH) ||
                    (command == CMD_DIV) || (command == CMD_REM);
  assign a_neg    = sgn1 & src1[XLEN-1];
  assign b_neg    = sgn2 & src2[XLEN-1];
  assign a_mag    = a_neg ? -src1 : src1;
  assign b_mag    = b_neg ? -src2 : src2;
  assign div_zero = (src2 == '0);
  assign ovf      = ((command == CMD_DIV) || (command == CMD_REM)) &&
                    (src1 == MIN_INT) && (src2 == '1);
  assign special  = is_div & (div_zero | ovf);
  // command[1] separates Rem/Remu from Div/Divu.
  assign special_res = div_zero ? (command[1] ? src1 : '1)
                                : (command[1] ? '0 : MIN_INT);

  // One iteration step for each datapath; acc_hi/acc_lo hold product or remainder/quotient.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              fits;
  logic [XLEN-1:0]   hi_n, lo_n, q_s, r_s, final_res;
  logic [2*XLEN-1:0] prod, prod_s;

  assign mul_sum   = {1'b0, acc_hi} + ({(XLEN+1){acc_lo[0]}} & {1'b0, mag});
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mag};
  assign fits      = ~div_diff[XLEN];

  always_comb begin
    if (state == Mul) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else begin
      hi_n = fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_n = {acc_lo[XLEN-2:0], fits};
    end
  end

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = neg_q ? -lo_n : lo_n;
  assign r_s    = neg_r ? -hi_n : hi_n;

  always_comb begin
    final_res = '0;
    if (state == Mul) final_res = (cmd == CMD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else              final_res = cmd[1] ? r_s : q_s;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= Idle;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) next_state = Idle;
    else begin
      case (state)
        Idle:    if (enable) next_state = special ? Done : (is_div ? Div : Mul);
        Mul,
        Div:     if (cnt == 5'd31) next_state = Done;
        Done:    next_state = Idle;
        default: next_state = Idle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      cmd    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      mag    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
    end else if (!flush) begin
      case (state)
        Idle: if (enable) begin
          cmd    <= command;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          cnt    <= '0;
          acc_hi <= '0;
          acc_lo <= is_div ? a_mag : b_mag;
          mag    <= is_div ? b_mag : a_mag;
          if (special) result <= special_res;
        end
        Mul, Div: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) result <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != Idle);
  assign done = (state == Done) & ~flush;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, special cases, flush/enable/reset hazards.
module tb_mul_div_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam int P_NONE = 0, P_EN = 1, P_FLUSH = 2, P_RST = 3;

  logic        clk = 1'b0;
  logic        rst, flush, enable;
  logic [2:0]  command;
  logic [31:0] src1, src2;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .enable(enable), .command(command),
    .src1(src1), .src2(src2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issues one op in the current cycle (cycle 0) and walks up to max_cyc cycles.
  // lat = cycle offset of the first done pulse, or -1 if none was seen.
  // A hazard (enable / flush / rst) can be poked during cycle poke_cyc; busy and result
  // are captured in the cycle right after it.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cyc, input int poke_kind, input int max_cyc,
                        output int lat, output logic [31:0] res,
                        output logic busy_after, output logic [31:0] res_after);
    command = c; src1 = a; src2 = b; enable = 1'b1;
    lat = -1; res = 'x; busy_after = 1'bx; res_after = 'x;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        enable = 1'b0; src1 = $urandom; src2 = $urandom; command = 3'($urandom);
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL busy_start cmd=%0d: got %b want 1", c, busy);
        end
      end
      if (cyc == poke_cyc + 1) begin
        flush = 1'b0; rst = 1'b0; enable = 1'b0;
        busy_after = busy; res_after = result;
      end
      if (cyc == poke_cyc) begin
        case (poke_kind)
          P_EN:    begin enable = 1'b1; command = DIVU; src1 = 32'd50; src2 = 32'd5; end
          P_FLUSH: flush = 1'b1;
          P_RST:   rst = 1'b1;
          default: ;
        endcase
        #1;
      end
      if (done === 1'b1) begin
        lat = cyc; res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; enable = 1'b0; command = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++; $display("FAIL reset: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table-driven iterative ops: done must arrive at exactly +33 and drop the cycle after.
  task automatic test_iterative();
    logic [2:0]  c  [8] = '{MUL, MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU};
    logic [31:0] a  [8] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] b  [8] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                            32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [8] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                            32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int lat; logic [31:0] res, ra; logic ba;
    for (int i = 0; i < 8; i++) begin
      run_op(c[i], a[i], b[i], -5, P_NONE, 40, lat, res, ba, ra);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL iter_latency[%0d]: got %0d want 33", i, lat); end
      checks++;
      if (res !== ex[i]) begin errors++; $display("FAIL iter_result[%0d]: got %h want %h", i, res, ex[i]); end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL iter_after[%0d]: got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  c  [4] = '{DIVU, REM, DIV, REM};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    int lat; logic [31:0] res, ra; logic ba;
    for (int i = 0; i < 4; i++) begin
      run_op(c[i], a[i], b[i], -5, P_NONE, 40, lat, res, ba, ra);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
      checks++;
      if (res !== ex[i]) begin errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, ex[i]); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL special_idle[%0d]: got busy=%b want 0", i, busy); end
    end
  endtask

  task automatic test_flush();
    int lat; logic [31:0] res, ra; logic ba;
    // Flush mid-divide, then a multiply issued in the very next cycle.
    run_op(DIV, 32'd1000, 32'd3, 10, P_FLUSH, 11, lat, res, ba, ra);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL flush_div_done: got done at %0d want none", lat); end
    checks++;
    if (ba !== 1'b0) begin errors++; $display("FAIL flush_div_busy: got %b want 0", ba); end
    run_op(MUL, 32'd3, 32'd4, -5, P_NONE, 40, lat, res, ba, ra);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL flush_mul_latency: got %0d want 33", lat); end
    checks++;
    if (res !== 32'd12) begin errors++; $display("FAIL flush_mul_result: got %h want 0000000c", res); end
    @(posedge clk); #1;
    // Flush coincident with the Done cycle hides done.
    run_op(MULHU, 32'h10, 32'h10, 33, P_FLUSH, 36, lat, res, ba, ra);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL flush_done_gate: got done at %0d want none", lat); end
    checks++;
    if (ba !== 1'b0) begin errors++; $display("FAIL flush_done_busy: got %b want 0", ba); end
    // Flush together with enable in Idle drops the request.
    enable = 1'b1; flush = 1'b1; command = MUL; src1 = 32'd2; src2 = 32'd2;
    @(posedge clk); #1;
    enable = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_drop: got busy=%b want 0", busy); end
  endtask

  task automatic test_hazards();
    int lat; logic [31:0] res, ra; logic ba;
    // Stray enable mid-multiply must not disturb it.
    run_op(MUL, 32'd7, 32'hFFFFFFFD, 5, P_EN, 40, lat, res, ba, ra);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL enable_ignored_latency: got %0d want 33", lat); end
    checks++;
    if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL enable_ignored_result: got %h want ffffffeb", res); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL enable_ignored_idle: got busy=%b want 0", busy); end
    // Reset mid-operation: no done, busy and result cleared.
    run_op(DIVU, 32'd100, 32'd7, 20, P_RST, 40, lat, res, ba, ra);
    checks++;
    if (lat !== -1) begin errors++; $display("FAIL rst_mid_done: got done at %0d want none", lat); end
    checks++;
    if (ba !== 1'b0 || ra !== 32'h0) begin
      errors++; $display("FAIL rst_mid_state: got busy=%b result=%h want 0 00000000", ba, ra);
    end
  endtask

  initial begin
    test_reset();
    test_iterative();
    test_special();
    test_flush();
    test_hazards();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
